// File: rtl/module_booth_mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Imported by the step datapath and the control top level.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam int MULT_WIDTH = 8;

  // {Q[0], q_1} pair encodings
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/module_booth_step.sv
// One radix-2 Booth step: add/sub M into A, then arithmetic
// shift {A,Q,q_1} right by one. Purely combinational.
module module_booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    unique case ({q_i[0], q1_i})
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
    a_o  = {sum[WIDTH], sum[WIDTH:1]};
    q_o  = {sum[0], q_i[WIDTH-1:1]};
    q1_o = q_i[0];
  end

endmodule

// File: rtl/module_booth_mult.sv
// Iterative signed Booth multiplier: edge-triggered start,
// one Booth step per clock, registered product/busy/done.
module module_booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     numero1_i,
  input  logic [WIDTH-1:0]     numero2_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t state_q, state_d;

  logic               valid_q;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               start;
  logic [WIDTH:0]     step_a;
  logic [WIDTH-1:0]   step_q;
  logic               step_q1;

  assign start = valid_i & ~valid_q;

  module_booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a),
    .q_o  (step_q),
    .q1_o (step_q1)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    // busy stays up through the cycle in which done pulses
    busy_d  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {numero1_i[WIDTH-1], numero1_i};
          a_d     = '0;
          q_d     = numero2_i;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prod_d  = {a_q[WIDTH-1:0], q_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_i;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: tb/tb_module_booth_mult.sv
// Scoreboard bench for module_booth_mult: directed vectors,
// decoupled monitor checks each done_o against queued products.
module tb_module_booth_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  numero1_i;
  logic [7:0]  numero2_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  module_booth_mult dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .numero1_i (numero1_i),
    .numero2_i (numero2_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    end
  endtask

  // monitor: pops one expected product per done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done_o === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 16'h1, 16'h0);
        end else begin
          chk("product", product_o, exp_q.pop_front());
        end
      end
    end
  end

  // start on a fresh valid edge, check latency and busy timing
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int n;
    @(negedge clk);
    numero1_i = a;
    numero2_i = b;
    valid_i   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk("busy_at_start", {15'h0, busy_o}, 16'h1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        n = i;
        break;
      end
    end
    chk("latency", 16'(n), 16'd9);
    chk("busy_in_done", {15'h0, busy_o}, 16'h1);
    @(posedge clk);
    #1;
    chk("busy_fall", {15'h0, busy_o}, 16'h0);
    chk("done_one_cycle", {15'h0, done_o}, 16'h0);
    valid_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    rst       = 1'b1;
    valid_i   = 1'b0;
    numero1_i = '0;
    numero2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {15'h0, busy_o}, 16'h0);
    chk("rst_done", {15'h0, done_o}, 16'h0);
    chk("rst_product", product_o, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    run(8'd3,   8'd5,   16'h000F);
    run(8'hFD,  8'd5,   16'hFFF1);
    run(8'd5,   8'hFD,  16'hFFF1);
    run(8'hF9,  8'hFA,  16'h002A);
    run(8'h80,  8'h80,  16'h4000);
    run(8'h80,  8'h7F,  16'hC080);
    run(8'h00,  8'hFF,  16'h0000);
    run(8'h7F,  8'h7F,  16'h3F01);

    // level held high: exactly one product
    d0 = n_done;
    @(negedge clk);
    numero1_i = 8'd4;
    numero2_i = 8'd6;
    valid_i   = 1'b1;
    exp_q.push_back(16'h0018);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("held_one_done", 16'(n_done - d0), 16'd1);
    valid_i = 1'b0;

    // re-pulse during CALC is ignored
    d0 = n_done;
    @(negedge clk);
    numero1_i = 8'd11;
    numero2_i = 8'd3;
    valid_i   = 1'b1;
    exp_q.push_back(16'h0021);
    @(posedge clk);
    repeat (2) @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("repulse_one_done", 16'(n_done - d0), 16'd1);
    valid_i = 1'b0;
    run(8'd2, 8'hFC, 16'hFFF8);

    // operands change mid-operation
    @(negedge clk);
    numero1_i = 8'd6;
    numero2_i = 8'd7;
    valid_i   = 1'b1;
    exp_q.push_back(16'h002A);
    @(posedge clk);
    repeat (2) @(negedge clk);
    numero1_i = 8'h11;
    numero2_i = 8'h55;
    repeat (15) @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;

    // async reset at CALC step 4
    d0 = n_done;
    @(negedge clk);
    numero1_i = 8'd3;
    numero2_i = 8'd5;
    valid_i   = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst     = 1'b1;
    valid_i = 1'b0;
    #1;
    chk("midrst_busy", {15'h0, busy_o}, 16'h0);
    chk("midrst_done", {15'h0, done_o}, 16'h0);
    chk("midrst_product", product_o, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", 16'(n_done - d0), 16'd0);
    run(8'd9, 8'd9, 16'h0051);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
